// File: rtl/multicycle_control_sequencer_pkg.sv
// Shared definitions for the multicycle control sequencer.
// Contents:
//   StateW / OpcodeW  : widths of the state code and the IR opcode field
//   state_e           : control-state encodings consumed by the decode block
//   Op*               : fixed opcodes with their own instruction class
//   op_class_t        : one-hot opcode class produced by the opcode class decoder
package multicycle_control_sequencer_pkg;

  localparam int unsigned StateW  = 4;
  localparam int unsigned OpcodeW = 6;

  // Codes 13-15 are unused and fall back to StIf.
  typedef enum logic [StateW-1:0] {
    StIf     = 4'd0,
    StRf     = 4'd1,
    StImm2   = 4'd2,
    StAluR3  = 4'd3,
    StAluRi3 = 4'd4,
    StAlu4   = 4'd5,
    StBr3    = 4'd6,
    StMem3   = 4'd7,
    StLoad4  = 4'd8,
    StStore4 = 4'd9,
    StLoad5  = 4'd10,
    StJump3  = 4'd11,
    StHalted = 4'd12
  } state_e;

  localparam logic [OpcodeW-1:0] OpLoad  = 6'h20;
  localparam logic [OpcodeW-1:0] OpStore = 6'h21;
  localparam logic [OpcodeW-1:0] OpBeq   = 6'h22;
  localparam logic [OpcodeW-1:0] OpJump  = 6'h23;
  localparam logic [OpcodeW-1:0] OpLi    = 6'h24;
  localparam logic [OpcodeW-1:0] OpHalt  = 6'h3F;

  typedef struct packed {
    logic r_type;
    logic ri_type;
    logic load;
    logic store;
    logic beq;
    logic jump;
    logic li;
    logic halt;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/multicycle_control_sequencer_if.sv
// Handshake and status bundle between the CPU datapath and the control sequencer.
// Signals:
//   run, opcode, mem_ready                     : datapath -> sequencer
//   state, mem_stall, instr_done, halted,
//   illegal, instr_count                       : sequencer -> datapath / decode
// Modports: master = datapath side, slave = sequencer side.
interface multicycle_control_sequencer_if
  import multicycle_control_sequencer_pkg::*;
#(
  parameter int unsigned COUNT_W = 32
);
  logic               run;
  logic [OpcodeW-1:0] opcode;
  logic               mem_ready;
  logic [StateW-1:0]  state;
  logic               mem_stall;
  logic               instr_done;
  logic               halted;
  logic               illegal;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    output run, opcode, mem_ready,
    input  state, mem_stall, instr_done, halted, illegal, instr_count
  );

  modport slave (
    input  run, opcode, mem_ready,
    output state, mem_stall, instr_done, halted, illegal, instr_count
  );
endinterface

// File: rtl/multicycle_control_sequencer_opcode_class_decode.sv
// Combinational opcode -> one-hot instruction class.
// Ports:
//   opcode_i : IR opcode field
//   class_o  : one-hot class (exactly one bit set for every opcode)
module multicycle_control_sequencer_opcode_class_decode
  import multicycle_control_sequencer_pkg::*;
(
  input  logic [OpcodeW-1:0] opcode_i,
  output op_class_t          class_o
);

  always_comb begin
    class_o = '0;
    unique casez (opcode_i)
      6'b00????: class_o.r_type  = 1'b1;
      6'b01????: class_o.ri_type = 1'b1;
      OpLoad:    class_o.load    = 1'b1;
      OpStore:   class_o.store   = 1'b1;
      OpBeq:     class_o.beq     = 1'b1;
      OpJump:    class_o.jump    = 1'b1;
      OpLi:      class_o.li      = 1'b1;
      OpHalt:    class_o.halt    = 1'b1;
      default:   class_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_sequencer.sv
// State register and next-state logic of the multicycle CPU control path.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave modport; run/opcode/mem_ready in, state/mem_stall/instr_done/
//           halted/illegal/instr_count out
// Parameters:
//   COUNT_W     : width of the retired-instruction counter (wraps)
//   RESET_STATE : state entered on reset
module multicycle_control_sequencer
  import multicycle_control_sequencer_pkg::*;
#(
  parameter int unsigned        COUNT_W     = 32,
  parameter logic [StateW-1:0]  RESET_STATE = 4'd0
)(
  input logic                          clk,
  input logic                          reset,
  multicycle_control_sequencer_if.slave bus
);

  state_e             state_q, state_d;
  logic               halted_q, halted_d;
  logic               illegal_q, illegal_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               mem_stall;
  logic               instr_done;
  op_class_t          op_class;

  multicycle_control_sequencer_opcode_class_decode u_opcode_class_decode (
    .opcode_i (bus.opcode),
    .class_o  (op_class)
  );

  always_comb begin
    state_d    = state_q;
    halted_d   = halted_q;
    illegal_d  = illegal_q;
    mem_stall  = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      // run is only honoured here, so a dropped run lets the current instruction finish.
      StIf: begin
        if (bus.run && bus.mem_ready) state_d = StRf;
        else                          mem_stall = 1'b1;
      end
      StRf: begin
        if (op_class.r_type)                      state_d = StAluR3;
        else if (op_class.ri_type)                state_d = StAluRi3;
        else if (op_class.load || op_class.store) state_d = StMem3;
        else if (op_class.beq)                    state_d = StBr3;
        else if (op_class.jump)                   state_d = StJump3;
        else if (op_class.li)                     state_d = StImm2;
        else begin
          state_d   = StHalted;
          halted_d  = 1'b1;
          illegal_d = op_class.illegal;
        end
      end
      StAluR3, StAluRi3: state_d = StAlu4;
      StMem3:            state_d = op_class.store ? StStore4 : StLoad4;
      StLoad4: begin
        if (bus.mem_ready) state_d = StLoad5;
        else               mem_stall = 1'b1;
      end
      StStore4: begin
        if (bus.mem_ready) begin
          state_d    = StIf;
          instr_done = 1'b1;
        end else begin
          mem_stall = 1'b1;
        end
      end
      StAlu4, StLoad5, StBr3, StJump3, StImm2: begin
        state_d    = StIf;
        instr_done = 1'b1;
      end
      StHalted: state_d = StHalted;
      default:  state_d = StIf;
    endcase
    count_d = instr_done ? count_q + COUNT_W'(1) : count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= state_e'(RESET_STATE);
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.mem_stall   = mem_stall;
  assign bus.instr_done  = instr_done;
  assign bus.halted      = halted_q;
  assign bus.illegal     = illegal_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control_sequencer.sv
// Self-checking bench for multicycle_control_sequencer.
// Two instances share stimulus: COUNT_W=32 and COUNT_W=4 (counter wrap).
// Each instruction is expanded into its expected per-cycle state trace from the
// instruction class and the chosen wait counts; every cycle is then checked.
module tb_multicycle_control_sequencer;

  localparam int C_R = 0, C_RI = 1, C_LOAD = 2, C_STORE = 3, C_BEQ = 4;
  localparam int C_JUMP = 5, C_LI = 6, C_HALT = 7, C_ILL = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_sequencer_if #(.COUNT_W(32)) bus ();
  multicycle_control_sequencer_if #(.COUNT_W(4))  bus4 ();

  assign bus4.run       = bus.run;
  assign bus4.opcode    = bus.opcode;
  assign bus4.mem_ready = bus.mem_ready;

  multicycle_control_sequencer #(.COUNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  multicycle_control_sequencer #(.COUNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] cnt_exp;
  logic        halted_exp;
  logic        illegal_exp;
  logic        force_run0 = 1'b0;

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  // run outside IF: random (must be ignored) unless a directed drop is requested
  function automatic logic rr();
    return force_run0 ? 1'b0 : rb();
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check at negedge, advance past posedge.
  task automatic step(input int st, input logic r, input logic rdy,
                      input logic stall, input logic done);
    bus.run       = r;
    bus.mem_ready = rdy;
    @(negedge clk);
    check("state", 32'(bus.state), 32'(st));
    check("mem_stall", 32'(bus.mem_stall), 32'(stall));
    check("instr_done", 32'(bus.instr_done), 32'(done));
    check("halted", 32'(bus.halted), 32'(halted_exp));
    check("illegal", 32'(bus.illegal), 32'(illegal_exp));
    check("instr_count", bus.instr_count, cnt_exp);
    check("instr_count4", 32'(bus4.instr_count), cnt_exp & 32'hF);
    @(posedge clk);
    #1;
    if (done) cnt_exp = cnt_exp + 1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.run = rb();
    @(posedge clk);
    #1;
    reset       = 1'b0;
    cnt_exp     = '0;
    halted_exp  = 1'b0;
    illegal_exp = 1'b0;
  endtask

  // n_run0: IF cycles with run=0, n_wait: IF cycles with mem_ready=0,
  // m_wait: LOAD4/STORE4 wait cycles.
  task automatic run_instr(input logic [5:0] op, input int cls, input int n_run0,
                           input int n_wait, input int m_wait);
    bus.opcode = op;
    repeat (n_run0) step(0, 1'b0, rb(), 1'b1, 1'b0);
    repeat (n_wait) step(0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1, rr(), rb(), 1'b0, 1'b0);
    case (cls)
      C_R:  begin step(3, rr(), rb(), 1'b0, 1'b0); step(5, rr(), rb(), 1'b0, 1'b1); end
      C_RI: begin step(4, rr(), rb(), 1'b0, 1'b0); step(5, rr(), rb(), 1'b0, 1'b1); end
      C_LOAD: begin
        step(7, rr(), rb(), 1'b0, 1'b0);
        repeat (m_wait) step(8, rr(), 1'b0, 1'b1, 1'b0);
        step(8, rr(), 1'b1, 1'b0, 1'b0);
        step(10, rr(), rb(), 1'b0, 1'b1);
      end
      C_STORE: begin
        step(7, rr(), rb(), 1'b0, 1'b0);
        repeat (m_wait) step(9, rr(), 1'b0, 1'b1, 1'b0);
        step(9, rr(), 1'b1, 1'b0, 1'b1);
      end
      C_BEQ:  step(6, rr(), rb(), 1'b0, 1'b1);
      C_JUMP: step(11, rr(), rb(), 1'b0, 1'b1);
      C_LI:   step(2, rr(), rb(), 1'b0, 1'b1);
      default: begin
        halted_exp  = 1'b1;
        illegal_exp = (cls == C_ILL);
        repeat (20) step(12, rb(), rb(), 1'b0, 1'b0);
      end
    endcase
  endtask

  initial begin
    logic [31:0] r;
    int          v;
    int          cls;
    logic [5:0]  op;

    bus.opcode    = 6'h00;
    bus.mem_ready = 1'b0;
    cnt_exp       = '0;
    halted_exp    = 1'b0;
    illegal_exp   = 1'b0;

    // Reset values
    do_reset();
    step(0, 1'b0, rb(), 1'b1, 1'b0);

    // R-type, no waits: 0,1,3,5
    run_instr(6'h05, C_R, 0, 0, 0);
    // LOAD with two LOAD4 waits: 0,1,7,8,8,8,10
    run_instr(6'h20, C_LOAD, 0, 0, 2);
    // STORE, no waits: 0,1,7,9
    run_instr(6'h21, C_STORE, 0, 0, 0);
    // run dropped mid RI instruction: completes, then holds in IF
    force_run0 = 1'b1;
    run_instr(6'h13, C_RI, 0, 0, 0);
    force_run0 = 1'b0;
    repeat (5) step(0, 1'b0, rb(), 1'b1, 1'b0);
    // Illegal opcode parks with both flags; reset clears
    run_instr(6'h2A, C_ILL, 1, 1, 0);
    do_reset();
    step(0, 1'b0, rb(), 1'b1, 1'b0);
    // Explicit HALT
    run_instr(6'h3F, C_HALT, 0, 0, 0);
    do_reset();

    // Randomized instruction stream
    for (int i = 0; i < 150; i++) begin
      v = $urandom_range(0, 99);
      r = $urandom;
      if      (v < 20) begin cls = C_R;     op = {2'b00, r[3:0]}; end
      else if (v < 40) begin cls = C_RI;    op = {2'b01, r[3:0]}; end
      else if (v < 52) begin cls = C_LOAD;  op = 6'h20; end
      else if (v < 64) begin cls = C_STORE; op = 6'h21; end
      else if (v < 74) begin cls = C_BEQ;   op = 6'h22; end
      else if (v < 84) begin cls = C_JUMP;  op = 6'h23; end
      else if (v < 96) begin cls = C_LI;    op = 6'h24; end
      else if (v < 98) begin cls = C_HALT;  op = 6'h3F; end
      else begin cls = C_ILL; op = 6'h25 + 6'(r % 26); end
      run_instr(op, cls, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3));
      if (cls == C_HALT || cls == C_ILL) do_reset();
    end

    // Counter wrap on the 4-bit instance
    do_reset();
    repeat (15) run_instr(6'h23, C_JUMP, 0, 0, 0);
    check("wrap_all_ones", 32'(bus4.instr_count), 32'hF);
    run_instr(6'h23, C_JUMP, 0, 0, 0);
    check("wrap_to_zero", 32'(bus4.instr_count), 32'h0);
    check("no_wrap_32", bus.instr_count, 32'd16);

    // Reset during a LOAD4 memory wait
    bus.opcode = 6'h20;
    step(0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(7, 1'b1, 1'b1, 1'b0, 1'b0);
    step(8, 1'b1, 1'b0, 1'b1, 1'b0);
    step(8, 1'b1, 1'b0, 1'b1, 1'b0);
    do_reset();
    step(0, 1'b0, rb(), 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_sequencer.md
Name: multicycle_control_sequencer

Overview:
State-register and next-state logic for the multicycle CPU. It produces the 4-bit `state` consumed by the control-decode block, and steps each instruction through fetch, register fetch, execute, memory and writeback. It stalls on memory handshakes, gates execution with a run enable, and counts retired instructions. Halt and illegal opcodes park the sequencer until reset.

Parameters:
COUNT_W, 32, width of retired-instruction counter
RESET_STATE, 4'd0, state entered on reset (INSTRUCTION_FETCH)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
run  in  1  level; 0 holds sequencer at next instruction boundary
opcode  in  6  IR opcode field; valid from REGISTER_FETCH onward
mem_ready  in  1  memory completed this cycle's access
state  out  4  current control state to the decode block
mem_stall  out  1  top level gates pcWrite/irWrite/regWrite with ~mem_stall
instr_done  out  1  one-cycle pulse on the last cycle of an instruction
halted  out  1  sticky; sequencer parked in HALTED
illegal  out  1  sticky; halt caused by undefined opcode
instr_count  out  COUNT_W  retired instructions, wraps at 2^COUNT_W

Behaviour:
- Reset is synchronous on rising clk with reset=1. Outputs after reset: state=IF(0), halted=0, illegal=0, instr_count=0. mem_stall and instr_done are combinational from state/mem_ready/run.
- State encodings: IF=0, RF=1, IMM2=2, ALU_R3=3, ALU_RI3=4, ALU4=5, BR3=6, MEM3=7, LOAD4=8, STORE4=9, LOAD5=10, JUMP3=11, HALTED=12. Codes 13-15 are unreachable and recover to IF on the next clock.
- Opcode classes, decoded in RF only:
  - opcode[5:4]=00: R-type ALU
  - opcode[5:4]=01: RI ALU
  - 6'h20: LOAD
  - 6'h21: STORE
  - 6'h22: BEQ
  - 6'h23: JUMP
  - 6'h24: LI
  - 6'h3F: HALT
  - all others: illegal
- Transitions:
  - IF: if run=0, hold in IF, mem_stall=1. If run=1 and mem_ready=0, hold, mem_stall=1. If run=1 and mem_ready=1, go to RF.
  - RF: R-type→ALU_R3; RI→ALU_RI3; LOAD/STORE→MEM3; BEQ→BR3; JUMP→JUMP3; LI→IMM2; HALT→HALTED (halted=1); illegal→HALTED (halted=1, illegal=1).
  - ALU_R3, ALU_RI3 → ALU4. MEM3: LOAD→LOAD4, STORE→STORE4.
  - LOAD4: hold while mem_ready=0 (mem_stall=1), then →LOAD5.
  - STORE4: hold while mem_ready=0 (mem_stall=1), then →IF.
  - ALU4, LOAD5, BR3, JUMP3, IMM2 → IF.
  - HALTED: self-loop until reset; run and mem_ready are ignored.
- Latency with mem_ready tied high: R/RI=4 cycles, LOAD=5, STORE=4, BEQ/JUMP/LI=3. Each wait cycle adds one cycle.
- instr_done=1 in the terminal state of an instruction, on its final cycle: ALU4, LOAD5, BR3, JUMP3, IMM2, or STORE4 with mem_ready=1. instr_count increments on the same edge it leaves that state. HALT and illegal are not counted.
- mem_stall is asserted only in IF (run=0 or mem_ready=0), LOAD4 and STORE4 with mem_ready=0; otherwise 0.
- run=0 mid-instruction: the current instruction completes; the sequencer then holds in IF.
- reset during any state, including a memory wait or HALTED: the next state is IF and the counter clears.
- opcode is sampled in RF and again in MEM3 for load/store. The IR does not change before IF, because irWrite is asserted only in IF.

Decomposition:
- Extend the shared control-states include with the HALTED=12 encoding and the state widths.
- Add opcode class constants (LOAD, STORE, BEQ, JUMP, LI, HALT) to the shared opcodes include.
- One natural sub-module, opcode_class_decode: combinational opcode→one-hot class. It is reused by the decode block for aluOP gating.

Test Plan:
- Reset then run=1, mem_ready=1, opcode=6'h05 → states 0,1,3,5,0; instr_done pulses once in state 5; instr_count=1.
- LOAD 6'h20 with mem_ready low for 2 cycles in LOAD4 → 0,1,7,8,8,8,10,0; mem_stall=1 for exactly the 2 wait cycles; count +1.
- STORE 6'h21, mem_ready=1 → 0,1,7,9,0 (4 cycles); instr_done in state 9.
- run dropped during ALU_RI3 (opcode 6'h13) → completes 4,5, then holds at 0 with mem_stall=1; no further count change until run=1.
- Opcode 6'h2A in RF → HALTED next cycle, halted=1, illegal=1; stays 12 for 20 cycles with run toggling. Reset → state 0, flags clear.
- Preload instr_count to all-ones via 2^COUNT_W−1 JUMPs (COUNT_W=4 override) → the next JUMP wraps the count to 0.
